// File: rtl/gf_pkg.sv
// Shared Galois-field decoder parameters and types for the Reed-Solomon stages.
// Also carries the Forney sequencer state encoding and its default settle latency.
package gf_pkg;

    localparam int SYMB_WIDTH = 8;
    localparam int T_LEN      = 4;
    localparam int ROOTS_NUM  = 8;

    localparam int unsigned FORNEY_DP_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2,
        NONE = 2'd3
    } forney_ctrl_state_t;

endpackage

// File: rtl/lib_mux_ffs.sv
// Find-first-set multiplexer: picks the first set request at or above the one-hot
// base position (wrapping), returns it one-hot and muxes out its data word.
module lib_mux_ffs #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [N-1:0]        base,
    input  logic [N-1:0]        req,
    input  logic [N-1:0][W-1:0] data,
    output logic [N-1:0]        sel_ffs,
    output logic [W-1:0]        dout
);

    logic [2*N-1:0] req2;
    logic [2*N-1:0] grant2;

    // Doubling the request vector lets a single subtraction handle the wrap-around.
    assign req2    = {req, req};
    assign grant2  = req2 & ~(req2 - {{N{1'b0}}, base});
    assign sel_ffs = grant2[N-1:0] | grant2[2*N-1:N];

    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_ffs[i]) dout = dout | data[i];
        end
    end

endmodule

// File: rtl/rs_forney_ctrl.sv
// Forney-stage sequencer: latches one decode job, holds it on the datapath for a
// fixed settle latency, captures magnitudes and streams out the valid corrections.
module rs_forney_ctrl
    import gf_pkg::*;
#(
    parameter int unsigned DP_LATENCY = FORNEY_DP_LATENCY
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic                                  s_vld,
    output logic                                  s_rdy,
    input  logic [T_LEN-1:0][SYMB_WIDTH-1:0]      s_err_pos,
    input  logic [T_LEN-1:0]                      s_err_pos_vld,
    input  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]  s_synd,
    input  logic                                  s_fail,
    output logic [T_LEN-1:0][SYMB_WIDTH-1:0]      dp_err_pos,
    output logic [T_LEN-1:0]                      dp_err_pos_vld,
    output logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]  dp_synd,
    output logic                                  dp_start,
    input  logic [T_LEN-1:0][SYMB_WIDTH-1:0]      dp_mag,
    output logic                                  m_vld,
    input  logic                                  m_rdy,
    output logic [SYMB_WIDTH-1:0]                 m_pos,
    output logic [SYMB_WIDTH-1:0]                 m_mag,
    output logic                                  m_last,
    output logic                                  m_none,
    output logic                                  m_fail,
    output logic                                  busy,
    output forney_ctrl_state_t                    fsm_state
);

    // Both streams use valid/ready: a beat transfers on the rising edge where
    // valid and ready are both high; a raised valid holds its payload until then.

    localparam logic [3:0] WAIT_INIT = 4'(DP_LATENCY - 1);
    localparam logic [T_LEN-1:0] ONE_MASK = {{(T_LEN-1){1'b0}}, 1'b1};

    forney_ctrl_state_t state_q, state_d;

    logic [3:0]                               wait_cnt_q;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0]         pos_q;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0]         mag_q;
    logic [T_LEN-1:0]                         mask_q;
    logic [T_LEN-1:0]                         rem_mask_q;
    logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]     synd_q;
    logic                                     fail_q;
    logic                                     dp_start_q;

    logic [T_LEN-1:0][2*SYMB_WIDTH-1:0]       mux_data;
    logic [T_LEN-1:0]                         sel;
    logic [2*SYMB_WIDTH-1:0]                  mux_out;
    logic                                     single_left;

    always_comb begin
        for (int i = 0; i < T_LEN; i++) mux_data[i] = {mag_q[i], pos_q[i]};
    end

    lib_mux_ffs #(
        .N (T_LEN),
        .W (2 * SYMB_WIDTH)
    ) u_sel (
        .base    (ONE_MASK),
        .req     (rem_mask_q),
        .data    (mux_data),
        .sel_ffs (sel),
        .dout    (mux_out)
    );

    assign single_left = (rem_mask_q != '0) && ((rem_mask_q & (rem_mask_q - ONE_MASK)) == '0);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        s_rdy   = 1'b0;
        m_vld   = 1'b0;
        m_last  = 1'b0;
        m_none  = 1'b0;
        m_pos   = '0;
        m_mag   = '0;
        case (state_q)
            IDLE: begin
                s_rdy = 1'b1;
                if (s_vld) state_d = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) state_d = ((mask_q != '0) && !fail_q) ? EMIT : NONE;
            end
            EMIT: begin
                m_vld  = 1'b1;
                m_pos  = mux_out[SYMB_WIDTH-1:0];
                m_mag  = mux_out[2*SYMB_WIDTH-1:SYMB_WIDTH];
                m_last = single_left;
                if (m_rdy && single_left) state_d = IDLE;
            end
            NONE: begin
                m_vld  = 1'b1;
                m_none = 1'b1;
                m_last = 1'b1;
                if (m_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wait_cnt_q <= '0;
            pos_q      <= '0;
            mag_q      <= '0;
            mask_q     <= '0;
            rem_mask_q <= '0;
            synd_q     <= '0;
            fail_q     <= 1'b0;
            dp_start_q <= 1'b0;
        end else begin
            dp_start_q <= 1'b0;
            if (state_q == IDLE && s_vld) begin
                pos_q      <= s_err_pos;
                mask_q     <= s_err_pos_vld;
                synd_q     <= s_synd;
                fail_q     <= s_fail;
                wait_cnt_q <= WAIT_INIT;
                dp_start_q <= 1'b1;
            end
            if (state_q == WAIT) begin
                if (wait_cnt_q == 4'd0) begin
                    mag_q      <= dp_mag;
                    rem_mask_q <= mask_q;
                end else begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                end
            end
            if (state_q == EMIT && m_rdy) rem_mask_q <= rem_mask_q & ~sel;
        end
    end

    assign dp_err_pos     = pos_q;
    assign dp_err_pos_vld = mask_q;
    assign dp_synd        = synd_q;
    assign dp_start       = dp_start_q;
    assign m_fail         = m_vld & fail_q;
    assign busy           = (state_q != IDLE);
    assign fsm_state      = state_q;

endmodule

// File: doc/rs_forney_ctrl.md
# rs_forney_ctrl

Per-codeword sequencer for the Reed-Solomon Forney stage. It accepts one decode job per handshake: error positions, the valid mask, syndromes and a failure flag from the Chien/Berlekamp stages. It holds the job stable on the Forney datapath inputs for a fixed settle latency, then captures the error magnitudes. It then serializes the valid (position, magnitude) pairs to the symbol corrector over a valid/ready stream.

## Interface
- DP_LATENCY, 2, cycles the Forney datapath needs from dp_start until dp_mag is valid; legal range 1..15
- T_LEN, SYMB_WIDTH, ROOTS_NUM: taken from gf_pkg, not local parameters
- aclk  in  1  clock; all state changes on its rising edge
- areset  in  1  reset, asynchronous and active-high
- s_vld  in  1  job valid
- s_rdy  out  1  job ready
- s_err_pos  in  SYMB_WIDTH x T_LEN  error positions
- s_err_pos_vld  in  T_LEN  mask; bit i qualifies s_err_pos[i]
- s_synd  in  SYMB_WIDTH x ROOTS_NUM  syndromes
- s_fail  in  1  upstream uncorrectable flag
- dp_err_pos  out  SYMB_WIDTH x T_LEN  registered positions to the datapath
- dp_err_pos_vld  out  T_LEN  registered mask
- dp_synd  out  SYMB_WIDTH x ROOTS_NUM  registered syndromes
- dp_start  out  1  one-cycle pulse; datapath inputs are new
- dp_mag  in  SYMB_WIDTH x T_LEN  error magnitudes from the datapath
- m_vld  out  1  output beat valid
- m_rdy  in  1  output beat ready
- m_pos  out  SYMB_WIDTH  error position
- m_mag  out  SYMB_WIDTH  error magnitude
- m_last  out  1  final beat of the job
- m_none  out  1  job carries no correction (zero errors or failure)
- m_fail  out  1  copy of the captured s_fail; constant for all beats of a job
- busy  out  1  high whenever the FSM state is not IDLE

## Operation
- FSM states:
  - IDLE: s_rdy=1. On s_vld & s_rdy, register all s_* fields, load wait_cnt=DP_LATENCY-1, go to WAIT.
  - WAIT: dp_start=1 in the first WAIT cycle only. wait_cnt decrements each cycle. On the edge where wait_cnt==0, capture dp_mag into mag_q and the mask into rem_mask. Next state is EMIT if the mask is nonzero and fail=0; otherwise NONE.
  - EMIT: select index k = lowest set bit of rem_mask. Drive m_pos=pos_q[k] and m_mag=mag_q[k]. m_last=1 when rem_mask has exactly one bit set. On m_vld & m_rdy, clear bit k; if m_last, go to IDLE.
  - NONE: a single beat with m_pos=0, m_mag=0, m_none=1, m_last=1. On handshake, go to IDLE.
- m_vld=1 exactly in EMIT and NONE.
- s_rdy=0 outside IDLE; jobs never overlap. s_* inputs are ignored outside IDLE.
- Output payload is stable while m_vld & !m_rdy. m_vld never drops without a handshake.
- dp_* registers hold the job until the next capture. They update only on the s handshake.
- The mask is taken as-is; non-contiguous masks are legal. The beat count equals popcount(mask).
- A magnitude of 0 in dp_mag is still emitted; no filtering.
- Reset (asynchronous, any state, including mid-stream) forces:
  - IDLE, s_rdy=1, m_vld=0, dp_start=0, busy=0
  - all dp_*, m_* data outputs = 0, rem_mask=0
  - an in-flight job is discarded, no partial resume.

## Timing
- C0 is the s handshake edge.
- dp_start is high in cycle C1. dp_mag is sampled at the end of cycle C1+DP_LATENCY-1.
- First m_vld is in cycle C1+DP_LATENCY.
- With m_rdy tied high: one beat per cycle, and a job with n errors occupies n+DP_LATENCY+1 cycles. s_rdy returns the cycle after the last handshake.
- wait_cnt width: 4 bits.

## Structure
- gf_pkg already supplies SYMB_WIDTH, T_LEN, ROOTS_NUM. Add to gf_pkg:
  - the FSM state enum forney_ctrl_state_t (IDLE, WAIT, EMIT, NONE)
  - the FORNEY_DP_LATENCY default constant
- Lowest-set-bit selection reuses lib_mux_ffs, with base = 1 and the data input = {mag_q[i], pos_q[i]}. The sel_ffs output gives the one-hot bit to clear.
- Everything else is inline: registers, counter, FSM.

## Test plan
All scenarios use T_LEN=4, DP_LATENCY=2.
- Mask 4'b1010, pos={0,7,0,3}, dp_mag={0,0x11,0,0x22}, m_rdy=1 -> beats (pos 7, mag 0x11), then (pos 3, mag 0x22, m_last=1). First m_vld 3 cycles after the handshake; s_rdy high again 2 cycles after that.
- Mask 0, fail=0 -> single beat m_none=1, m_last=1, m_pos=0, m_mag=0.
- Mask 4'b1111 with s_fail=1 -> single NONE beat with m_fail=1; dp_start still pulses once.
- Mask 4'b1111, m_rdy toggling 1/0 -> 4 beats in index order 0..3, payload held while stalled; s_vld held high during the job is not accepted until IDLE.
- areset pulsed during the second EMIT beat -> m_vld=0 and s_rdy=1 immediately. A new job (mask 4'b0001) then emits exactly one beat with its own data.
- Back-to-back jobs with s_vld always high and m_rdy=1 -> no dropped or duplicated beats across 100 random jobs; beat count per job equals popcount(mask), or 1 if the mask is 0 or fail=1.
